// File: rtl/aes_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_encrypt_iter
// Purpose  : Iterative AES encryption engine. Executes one cipher round per
//            clock using one SubBytes / ShiftRows / MixColumns / AddRoundKey
//            datapath. Round keys are fetched from an external key-schedule
//            store addressed by key_idx. Block input and ciphertext output use
//            valid/ready handshakes.
// Config   : define AES_ENC_ABORT_EN to add the `abort` input, which drops the
//            block in flight and returns the engine to idle.
// Revision : 1.0  initial release
// ============================================================================
module aes_encrypt_iter #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      key_round,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef AES_ENC_ABORT_EN
  input  logic              abort,
`endif
  output logic [127:0]      out_block,
  output logic              busy
);

  // Elaboration-time parameter sanity
  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_encrypt_iter: NR must be 10, 12 or 14");
    end
    if ((1 << KIDX_W) <= NR) begin : g_bad_kidx
      $error("aes_encrypt_iter: KIDX_W too narrow to address NR+1 round keys");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, zero maps to zero) + affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, v;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    v    = gf_mul(x127, x127);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // ------------------------------------------------------------ round steps
  // State byte i sits at [127-8*i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  // ------------------------------------------------------------------ state
  state_t              r_state;
  logic [KIDX_W-1:0]   r_cnt;
  logic [127:0]        r_st;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_abort;
  logic                w_accept;
  logic                w_last;
  logic [127:0]        w_sb;
  logic [127:0]        w_sr;
  logic [127:0]        w_mc;
  logic [127:0]        w_ark_in;
  logic [127:0]        w_ark;

`ifdef AES_ENC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // A new block may enter from idle, or from done when the output retires
  // on the same edge; abort blocks any acceptance.
  assign in_ready = ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready)) & ~w_abort;
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == KIDX_W'(NR));

  // key_idx depends only on FSM state and round counter
  assign key_idx  = (r_state == S_ROUND) ? r_cnt : '0;

  // Single round datapath; the last round bypasses MixColumns. Outside the
  // round state the one AddRoundKey performs the initial whitening of
  // in_block with round key 0.
  assign w_sb     = sub_bytes(r_st);
  assign w_sr     = shift_rows(w_sb);
  assign w_mc     = mix_columns(w_sr);
  assign w_ark_in = (r_state == S_ROUND) ? (w_last ? w_sr : w_mc) : in_block;
  assign w_ark    = w_ark_in ^ key_round;

  // The state register doubles as the ciphertext holding register; it is
  // only written on accept or during rounds, so it is stable in S_DONE.
  assign out_block = r_st;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  // Round FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_st        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_abort && (r_state != S_IDLE)) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_st    <= w_ark;
            r_cnt   <= KIDX_W'(1);
            r_state <= S_ROUND;
            r_busy  <= 1'b1;
          end
        end
        S_ROUND: begin
          r_st <= w_ark;
          if (w_last) begin
            r_cnt       <= '0;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + KIDX_W'(1);
          end
        end
        S_DONE: begin
          if (w_accept) begin
            r_st        <= w_ark;
            r_cnt       <= KIDX_W'(1);
            r_state     <= S_ROUND;
            r_out_valid <= 1'b0;
          end else if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encrypt_iter
// Purpose  : Self-checking bench for aes_encrypt_iter. Three engines
//            (NR = 10, 12, 14) run against a byte-array AES reference model
//            with its own S-box generator and key expansion.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_encrypt_iter;

  localparam int NI = 3;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K3   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT3  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT3  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_block  [NI];
  logic [3:0]   key_idx   [NI];
  logic [127:0] key_round [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_block [NI];
  logic         busy      [NI];
`ifdef AES_ENC_ABORT_EN
  logic         abort     [NI];
`endif
  logic [127:0] rk [NI][16];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      assign key_round[g] = rk[g][key_idx[g]];
      aes_encrypt_iter #(.NR(10 + 2*g), .KIDX_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_block  (in_block[g]),
        .key_idx   (key_idx[g]),
        .key_round (key_round[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
`ifdef AES_ENC_ABORT_EN
        .abort     (abort[g]),
`endif
        .out_block (out_block[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int nr_of(input int i);
    return 10 + 2*i;
  endfunction

  // ------------------------------------------------------- reference model
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) r = r ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Walk generator 3 and its inverse simultaneously to fill the S-box
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Standard key expansion into the engine's round-key table
  task automatic load_key(input int i, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, nk;
    nr = nr_of(i); nk = nr - 6;
    for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
    rc = 8'h01;
    for (int k = nk; k < 4*(nr+1); k++) begin
      t = w[k-1];
      if (k % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && k % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[k] = w[k-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_enc(input int i, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] blk;
    int nr;
    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    nr  = nr_of(i);
    blk = pt ^ rk[i][0];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[blk[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(base[(j-row+4)%4], t[j+4*c]);
            s[row+4*c] = acc;
          end
      end else begin
        s = t;
      end
      for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = s[k];
      blk = blk ^ rk[i][r];
    end
    return blk;
  endfunction

  // ---------------------------------------------------------------- monitor
  // pend: a block is inside the engine; rnd: round index expected on key_idx
  // (0 when not in rounds). A pending block with rnd==0 is awaiting output.
  bit           pend  [NI];
  int           rnd   [NI];
  logic [127:0] expct [NI];
  int           nout  [NI];
  bit           m_ab, m_ov, m_ir;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      m_ab = 1'b0;
`ifdef AES_ENC_ABORT_EN
      m_ab = abort[i];
`endif
      if (!rst_n) begin
        pend[i] = 1'b0;
        rnd[i]  = 0;
      end else begin
        m_ov = pend[i] && (rnd[i] == 0);
        m_ir = (!pend[i] || (m_ov && out_ready[i])) && !m_ab;
        check_eq($sformatf("in_ready[%0d]", i), in_ready[i], m_ir);
        check_eq($sformatf("out_valid[%0d]", i), out_valid[i], m_ov);
        check_eq($sformatf("busy[%0d]", i), busy[i], pend[i]);
        check_eq($sformatf("key_idx[%0d]", i), key_idx[i], rnd[i]);
        if (m_ov) check_eq($sformatf("out_block[%0d]", i), out_block[i], expct[i]);
        if (m_ab) begin
          if (pend[i]) begin pend[i] = 1'b0; rnd[i] = 0; end
        end else begin
          if (rnd[i] > 0) rnd[i] = (rnd[i] == nr_of(i)) ? 0 : rnd[i] + 1;
          if (m_ov && out_ready[i]) begin pend[i] = 1'b0; nout[i]++; end
          if (m_ir && in_valid[i]) begin
            pend[i]  = 1'b1;
            rnd[i]   = 1;
            expct[i] = ref_enc(i, in_block[i]);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input int i, input logic [127:0] pt);
    in_block[i] = pt;
    in_valid[i] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready[i]) begin
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        return;
      end
    end
    check_eq($sformatf("send_timeout[%0d]", i), in_ready[i], 1'b1);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid[i] && n < 200);
    if (!out_valid[i]) check_eq($sformatf("ov_timeout[%0d]", i), out_valid[i], 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0;
    build_sbox();
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; in_block[i] = '0; out_ready[i] = 1'b1;
      pend[i] = 1'b0; rnd[i] = 0; nout[i] = 0; expct[i] = '0;
`ifdef AES_ENC_ABORT_EN
      abort[i] = 1'b0;
`endif
      for (int r = 0; r < 16; r++) rk[i][r] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  in_ready[0],  1'b1);
    check_eq("rst_out_valid", out_valid[0], 1'b0);
    check_eq("rst_busy",      busy[0],      1'b0);
    check_eq("rst_key_idx",   key_idx[0],   4'd0);
    check_eq("rst_out_block", out_block[0], 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector 1 on the 10-round engine, with latency measured in edges
    load_key(0, {K1, 128'h0});
    check_eq("model_kat128", ref_enc(0, PT1), CT1);
    send(0, PT1);
    wait_valid(0, n);
    check_eq("latency_nr10", n, 10);
    check_eq("kat128_ct", out_block[0], CT1);
    @(posedge clk); #1;

    // 12- and 14-round engines, held under backpressure until both finish
    load_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    load_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check_eq("model_kat192", ref_enc(1, PT1), C192);
    check_eq("model_kat256", ref_enc(2, PT1), C256);
    out_ready[1] = 1'b0; out_ready[2] = 1'b0;
    send(1, PT1);
    send(2, PT1);
    wait_valid(2, n);
    check_eq("kat192_ct", out_block[1], C192);
    check_eq("kat256_ct", out_block[2], C256);
    out_ready[1] = 1'b1; out_ready[2] = 1'b1;
    @(posedge clk); #1;

    // Vector 3 held 20 cycles with out_ready low and a competing input
    load_key(0, {K3, 128'h0});
    out_ready[0] = 1'b0;
    send(0, PT3);
    wait_valid(0, n);
    in_block[0] = PT1; in_valid[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("hold_ct", out_block[0], CT3);
      check_eq("hold_in_ready", in_ready[0], 1'b0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;

    // Back-to-back alternating vectors 1 and 3 through the done-state accept
    n0 = nout[0];
    load_key(0, {K1, 128'h0});
    in_block[0] = PT1; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int b = 0; b < 6; b++) begin
      wait_valid(0, n);
      check_eq($sformatf("b2b_interval_%0d", b), n, 11);
      check_eq($sformatf("b2b_ct_%0d", b), out_block[0], (b % 2 == 0) ? CT1 : CT3);
      if (b < 5) begin
        load_key(0, {((b % 2 == 0) ? K3 : K1), 128'h0});
        in_block[0] = (b % 2 == 0) ? PT3 : PT1;
      end else begin
        in_valid[0] = 1'b0;
      end
    end
    @(posedge clk); #1;
    check_eq("b2b_count", nout[0] - n0, 6);

    // Reset pulse in the middle of round 5, then a clean encryption
    load_key(0, {K1, 128'h0});
    send(0, PT1);
    for (int k = 0; k < 20 && key_idx[0] != 4'd5; k++) begin
      @(posedge clk); #1;
    end
    check_eq("mid_rst_reached_cnt5", key_idx[0], 4'd5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready",  in_ready[0],  1'b1);
    check_eq("mid_rst_out_valid", out_valid[0], 1'b0);
    check_eq("mid_rst_busy",      busy[0],      1'b0);
    check_eq("mid_rst_key_idx",   key_idx[0],   4'd0);
    check_eq("mid_rst_out_block", out_block[0], 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, PT1);
    wait_valid(0, n);
    check_eq("post_rst_ct", out_block[0], CT1);
    @(posedge clk); #1;

`ifdef AES_ENC_ABORT_EN
    // Abort mid-rounds
    send(0, PT1);
    for (int k = 0; k < 20 && key_idx[0] != 4'd3; k++) begin
      @(posedge clk); #1;
    end
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check_eq("abort_rnd_out_valid", out_valid[0], 1'b0);
    check_eq("abort_rnd_busy",      busy[0],      1'b0);
    check_eq("abort_rnd_in_ready",  in_ready[0],  1'b1);
    repeat (12) @(posedge clk);
    #1;
    // Abort in done with both handshakes offered
    out_ready[0] = 1'b0;
    send(0, PT1);
    wait_valid(0, n);
    n0 = nout[0];
    abort[0] = 1'b1; out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_block[0] = PT3;
    @(posedge clk); #1;
    abort[0] = 1'b0; in_valid[0] = 1'b0;
    check_eq("abort_done_out_valid", out_valid[0], 1'b0);
    check_eq("abort_done_busy",      busy[0],      1'b0);
    check_eq("abort_done_no_output", nout[0] - n0, 0);
    load_key(0, {K3, 128'h0});
    send(0, PT3);
    wait_valid(0, n);
    check_eq("post_abort_ct", out_block[0], CT3);
    @(posedge clk); #1;
`endif

    // Randomized traffic with random keys and backpressure on all engines
    for (int i = 0; i < NI; i++) begin
      load_key(i, {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom});
    end
    n0 = nout[0] + nout[1] + nout[2];
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        in_block[i]  = {$urandom, $urandom, $urandom, $urandom};
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    check_eq("rand_drained_busy0", busy[0], 1'b0);
    check_eq("rand_some_outputs", (nout[0] + nout[1] + nout[2] - n0) > 30, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
